// File: rtl/reg_file_pkg.sv
// Shared widths and packed request/response bundles
// for the architectural register file.
package reg_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_TAG_W  = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_TAG_W-1:0]  tag;
  } reg_file_rd_req_pkt_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } reg_file_wr_req_pkt_t;

  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic [RF_TAG_W-1:0]  tag;
  } reg_file_rd_rsp_pkt_t;

endpackage

// File: rtl/reg_file_if.sv
// Read/write request and read response bundle
// between a requester (master) and the register file (slave).
interface reg_file_if #(
  parameter int NUM_RD_PORTS = 2
);
  import reg_file_pkg::*;

  logic [NUM_RD_PORTS-1:0] reg_file_rd_req_vld;
  reg_file_rd_req_pkt_t [NUM_RD_PORTS-1:0] reg_file_rd_req_pkt;
  logic reg_file_wr_req_vld;
  reg_file_wr_req_pkt_t reg_file_wr_req_pkt;
  logic [NUM_RD_PORTS-1:0] reg_file_rd_rsp_vld;
  reg_file_rd_rsp_pkt_t [NUM_RD_PORTS-1:0] reg_file_rd_rsp_pkt;

  modport master (
    output reg_file_rd_req_vld,
    output reg_file_rd_req_pkt,
    output reg_file_wr_req_vld,
    output reg_file_wr_req_pkt,
    input  reg_file_rd_rsp_vld,
    input  reg_file_rd_rsp_pkt
  );

  modport slave (
    input  reg_file_rd_req_vld,
    input  reg_file_rd_req_pkt,
    input  reg_file_wr_req_vld,
    input  reg_file_wr_req_pkt,
    output reg_file_rd_rsp_vld,
    output reg_file_rd_rsp_pkt
  );

endinterface

// File: rtl/reg_file.sv
// Multi-read-port register file, r0 hardwired to zero,
// registered 1-cycle read with same-cycle write bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_REGS     = 32,
  parameter int DATA_W       = RF_DATA_W
) (
  input logic       clk,
  input logic       reset,
  reg_file_if.slave rf
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [NUM_RD_PORTS-1:0] rsp_vld_q;
  reg_file_rd_rsp_pkt_t [NUM_RD_PORTS-1:0] rsp_pkt_q;
  reg_file_rd_rsp_pkt_t [NUM_RD_PORTS-1:0] rsp_pkt_d;

  logic                 wr_en;
  logic [RF_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;

  assign wr_addr = rf.reg_file_wr_req_pkt.addr;
  assign wr_data = rf.reg_file_wr_req_pkt.data;
  assign wr_en   = rf.reg_file_wr_req_vld
                 && (wr_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Idle ports keep their last packet; reads see this cycle's write.
  always_comb begin
    rsp_pkt_d = rsp_pkt_q;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rf.reg_file_rd_req_vld[p]) begin
        rsp_pkt_d[p].tag = rf.reg_file_rd_req_pkt[p].tag;
        unique case (1'b1)
          (rf.reg_file_rd_req_pkt[p].addr == '0):
            rsp_pkt_d[p].data = '0;
          (wr_en && rf.reg_file_rd_req_pkt[p].addr
                    == wr_addr):
            rsp_pkt_d[p].data = wr_data;
          default:
            rsp_pkt_d[p].data =
              regs_q[rf.reg_file_rd_req_pkt[p].addr];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_vld_q <= '0;
      rsp_pkt_q <= '0;
    end else begin
      rsp_vld_q <= rf.reg_file_rd_req_vld;
      rsp_pkt_q <= rsp_pkt_d;
    end
  end

  assign rf.reg_file_rd_rsp_vld = rsp_vld_q;
  assign rf.reg_file_rd_rsp_pkt = rsp_pkt_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed checks of reg_file against
// an array-based architectural model.
module tb_reg_file;
  import reg_file_pkg::*;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_file_if #(.NUM_RD_PORTS(NP)) rf ();

  reg_file #(
    .NUM_RD_PORTS(NP),
    .NUM_REGS(32),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rf(rf.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] model [32];
  logic [31:0] last_data [NP];
  logic [3:0]  last_tag [NP];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  task automatic set_rd(input int p, input bit v,
                        input logic [4:0] a,
                        input logic [3:0] t);
    rf.reg_file_rd_req_vld[p] = v;
    rf.reg_file_rd_req_pkt[p].addr = a;
    rf.reg_file_rd_req_pkt[p].tag = t;
  endtask

  task automatic set_wr(input bit v,
                        input logic [4:0] a,
                        input logic [31:0] d);
    rf.reg_file_wr_req_vld = v;
    rf.reg_file_wr_req_pkt.addr = a;
    rf.reg_file_wr_req_pkt.data = d;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) set_rd(p, 0, 0, 0);
    set_wr(0, 0, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int p = 0; p < NP; p++) begin
      last_data[p] = '0;
      last_tag[p] = '0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"},
          32'(rf.reg_file_rd_rsp_vld), 32'd0);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_data%0d", tag, p),
            rf.reg_file_rd_rsp_pkt[p].data, 32'd0);
      check($sformatf("%s_tag%0d", tag, p),
            32'(rf.reg_file_rd_rsp_pkt[p].tag), 32'd0);
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick(input string tag);
    logic [NP-1:0] ev;
    logic [4:0] a;
    logic [4:0] wa;
    bit wv;
    ev = '0;
    wv = rf.reg_file_wr_req_vld;
    wa = rf.reg_file_wr_req_pkt.addr;
    for (int p = 0; p < NP; p++) begin
      if (rf.reg_file_rd_req_vld[p]) begin
        ev[p] = 1'b1;
        a = rf.reg_file_rd_req_pkt[p].addr;
        if (a == 0)
          last_data[p] = '0;
        else if (wv && wa == a)
          last_data[p] = rf.reg_file_wr_req_pkt.data;
        else
          last_data[p] = model[a];
        last_tag[p] = rf.reg_file_rd_req_pkt[p].tag;
      end
    end
    if (wv && wa != 0)
      model[wa] = rf.reg_file_wr_req_pkt.data;
    @(posedge clk);
    #1;
    check({tag, "_vld"},
          32'(rf.reg_file_rd_rsp_vld), 32'(ev));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_data%0d", tag, p),
            rf.reg_file_rd_rsp_pkt[p].data, last_data[p]);
      check($sformatf("%s_tag%0d", tag, p),
            32'(rf.reg_file_rd_rsp_pkt[p].tag),
            32'(last_tag[p]));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] wa;
    idle();
    clear_model();
    reset = 1'b1;
    // Requests during reset must be ignored.
    set_rd(0, 1, 5, 7);
    set_wr(1, 5, 32'h1111_2222);
    repeat (2) @(negedge clk);
    check_reset_state("in_reset");
    idle();
    reset = 1'b0;

    set_rd(0, 1, 5, 3);
    tick("r5_after_reset");
    idle();

    set_wr(1, 7, 32'hDEAD_BEEF);
    tick("wr_r7");
    set_wr(0, 0, 0);
    set_rd(0, 1, 7, 1);
    set_rd(1, 1, 7, 2);
    tick("rd_r7_both");
    idle();

    set_wr(1, 9, 32'h1234_5678);
    set_rd(1, 1, 9, 5);
    tick("bypass_r9");
    idle();

    set_wr(1, 0, 32'hFFFF_FFFF);
    set_rd(0, 1, 0, 1);
    set_rd(1, 1, 0, 2);
    tick("r0_same");
    set_wr(0, 0, 0);
    tick("r0_next");
    idle();

    set_wr(1, 3, 32'hA5A5_A5A5);
    set_rd(0, 1, 3, 2);
    tick("wr_r3");
    set_wr(0, 0, 0);
    set_rd(0, 1, 3, 4);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    clear_model();
    @(posedge clk);
    #1;
    check_reset_state("rst_edge");
    @(negedge clk);
    idle();
    reset = 1'b0;
    set_rd(0, 1, 3, 6);
    tick("r3_after_rst");
    idle();

    for (int i = 1; i < 32; i++) begin
      set_wr(1, 5'(i), 32'(i));
      tick("fill");
    end
    set_wr(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_rd(0, 1, 5'(i), 4'(i));
      tick($sformatf("seq_r%0d", i));
    end
    idle();
    tick("seq_idle");

    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      set_wr(1'($urandom), wa, $urandom);
      for (int p = 0; p < NP; p++)
        set_rd(p, 1'($urandom),
               ($urandom_range(0, 1) == 0) ? wa
                 : 5'($urandom_range(0, 31)),
               4'($urandom));
      tick("rand");
    end
    idle();
    tick("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001: Parameter NUM_RD_PORTS, default 2, number of independent read ports.
REQ-002: Parameter NUM_REGS, default 32, architectural register count; index width is clog2(NUM_REGS) = 5.
REQ-003: Parameter DATA_W, default 32, register data width.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: reset  input  1  reset, asynchronous and active-high.
REQ-006: reg_file_rd_req_vld  input  [NUM_RD_PORTS-1:0]  per-port read request valid.
REQ-007: reg_file_rd_req_pkt  input  [NUM_RD_PORTS-1:0] of reg_file_rd_req_pkt_t  per-port request; field addr[4:0], field tag[3:0] (opaque, returned unchanged).
REQ-008: reg_file_wr_req_vld  input  1  write request valid.
REQ-009: reg_file_wr_req_pkt  input  reg_file_wr_req_pkt_t  write request; fields addr[4:0] and data[DATA_W-1:0].
REQ-010: reg_file_rd_rsp_vld  output  [NUM_RD_PORTS-1:0]  per-port read response valid.
REQ-011: reg_file_rd_rsp_pkt  output  [NUM_RD_PORTS-1:0] of reg_file_rd_rsp_pkt_t  per-port response; fields data[DATA_W-1:0] and tag[3:0].
REQ-012: All packet types SHALL be packed structs in reg_file_pkg.

Function
REQ-013: Storage SHALL be NUM_REGS x DATA_W flops; register 0 SHALL read as 0 at all times.
REQ-014: A write with reg_file_wr_req_vld=1 and addr!=0 SHALL update the register at the next rising edge; writes to addr 0 SHALL be discarded.
REQ-015: Read latency SHALL be exactly 1 cycle: request valid in cycle N -> rsp_vld for that port high in cycle N+1, carrying the data and tag of the cycle-N request.
REQ-016: rsp_vld[p] SHALL be low in cycle N+1 when rd_req_vld[p] was low in cycle N; rsp_pkt contents are don't-care when rsp_vld is low but SHALL hold their last value (no toggling on idle cycles).
REQ-017: No backpressure: every accepted request SHALL produce exactly one response; there is no ready signal.
REQ-018: Write-to-read bypass: a read in cycle N to an address written (vld=1, addr!=0) in the same cycle N SHALL return the new write data in cycle N+1.
REQ-019: A read of addr 0 in the same cycle as a write to addr 0 SHALL return 0.
REQ-020: Multiple ports reading the same address in the same cycle SHALL all receive identical data.
REQ-021: Ports SHALL be fully independent; no ordering or arbitration between ports.
REQ-022: Response data SHALL come from the response register stage, not combinationally from request inputs.

Reset
REQ-023: While reset is high, all NUM_REGS registers SHALL be 0, rsp_vld SHALL be all 0, and rsp_pkt SHALL be all 0.
REQ-024: Reset assertion SHALL take effect asynchronously, without a clock edge; a request in flight when reset asserts SHALL produce no response.
REQ-025: Requests and writes presented while reset is high SHALL be ignored; the first request accepted is on the first rising edge with reset low.

Verification
REQ-026: Reset then read r5 on port 0 tag 3 -> cycle+1: rsp_vld=2'b01, data=0, tag=3.
REQ-027: Write r7=0xDEADBEEF, next cycle read r7 on both ports -> cycle+1: rsp_vld=2'b11, both data=0xDEADBEEF.
REQ-028: Same-cycle write r9=0x12345678 and port 1 read r9 (prior value 0) -> cycle+1: port 1 data=0x12345678 (bypass).
REQ-029: Write r0=0xFFFFFFFF, same and following cycle read r0 -> data=0 both times.
REQ-030: Write r3=0xA5A5A5A5, issue read r3, assert reset asynchronously mid-cycle before the next edge -> rsp_vld=0 immediately; after release, read r3 returns 0.
REQ-031: Back-to-back reads on port 0 for 32 consecutive cycles to r0..r31 after writing r[i]=i -> 32 consecutive responses with data=i (0 for r0), no gaps.
